// File: rtl/delay_scheduler.sv
// Shared programmable delay channel: latches per-requester triggers, grants them
// round-robin onto one down-counter, and spaces consecutive delays by a guard gap.

module delay_pending_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic clear,
    output logic pending,
    output logic hit
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= 1'b0;
        else          pending <= req | (pending & ~clear);
    end

    // A repeat request on an already-pending, not-being-granted slot merges.
    assign hit = req & pending & ~clear;
endmodule

module delay_scheduler #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CW    = 16,
    parameter int GUARD = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   delay_cycles,
    output logic [NREQ-1:0] pending,
    output logic            busy,
    output logic            start,
    output logic [IDW-1:0]  grant_id,
    output logic            done,
    output logic [IDW-1:0]  done_id,
    output logic            overrun
);
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GUARD} state_t;

    localparam logic [CW-1:0]  GLOAD     = (GUARD > 0) ? CW'(GUARD - 1) : '0;
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  last, winner;
    logic            found, grant;
    logic [NREQ-1:0] clear, hit;
    logic [CW-1:0]   cnt, gcnt;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        delay_pending_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req[i]),
            .clear   (clear[i]),
            .pending (pending[i]),
            .hit     (hit[i])
        );
    end

    // Round-robin: first pending index after the last winner, wrapping at NREQ.
    always_comb begin
        int j;
        j      = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && pending[j]) begin
                found  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

    assign grant = (state == S_IDLE) && found;
    assign busy  = (state != S_IDLE);

    always_comb begin
        clear = '0;
        if (grant) clear[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_COUNT;
            S_COUNT: if (cnt == '0) state_nxt = (GUARD > 0) ? S_GUARD : S_IDLE;
            S_GUARD: if (gcnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            gcnt     <= '0;
            last     <= LAST_INIT;
            grant_id <= '0;
            done_id  <= '0;
            start    <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            start   <= grant;
            done    <= (state == S_COUNT) && (cnt == '0);
            overrun <= |hit;
            if (grant) begin
                grant_id <= winner;
                last     <= winner;
                // A zero-length request behaves exactly like a one-cycle delay.
                cnt      <= (delay_cycles == '0) ? '0 : delay_cycles - CW'(1);
            end
            if (state == S_COUNT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    done_id <= grant_id;
                    gcnt    <= GLOAD;
                end
            end
            if (state == S_GUARD && gcnt != '0) gcnt <= gcnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler: a GUARD=2 and a GUARD=0 instance, with
// expected start/done/overrun events queued at stimulus time and popped on output.

module tb_delay_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CW   = 16;

    typedef struct {int cyc; int id;} ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [NREQ-1:0] req_a, req_b, pending_a, pending_b;
    logic [CW-1:0]   dly_a, dly_b;
    logic            busy_a, start_a, done_a, overrun_a;
    logic            busy_b, start_b, done_b, overrun_b;
    logic [IDW-1:0]  grant_id_a, done_id_a, grant_id_b, done_id_b;

    ev_t sa[$], da[$], sb[$], db[$];
    int  oa[$], ob[$];
    ev_t ea, eb;
    int  oc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_scheduler #(.NREQ(NREQ), .IDW(IDW), .CW(CW), .GUARD(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .delay_cycles(dly_a),
        .pending(pending_a), .busy(busy_a), .start(start_a), .grant_id(grant_id_a),
        .done(done_a), .done_id(done_id_a), .overrun(overrun_a)
    );

    delay_scheduler #(.NREQ(NREQ), .IDW(IDW), .CW(CW), .GUARD(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .delay_cycles(dly_b),
        .pending(pending_b), .busy(busy_b), .start(start_b), .grant_id(grant_id_b),
        .done(done_b), .done_id(done_id_b), .overrun(overrun_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < t) check("wait_bound", cyc, t);
    endtask

    always @(negedge clk) begin
        if (start_a) begin
            if (sa.size() == 0) check("a_start_unexpected", sa.size(), 1);
            else begin
                ea = sa.pop_front();
                check("a_start_cyc", cyc, ea.cyc);
                check("a_start_id", grant_id_a, ea.id);
            end
        end
        if (done_a) begin
            if (da.size() == 0) check("a_done_unexpected", da.size(), 1);
            else begin
                ea = da.pop_front();
                check("a_done_cyc", cyc, ea.cyc);
                check("a_done_id", done_id_a, ea.id);
            end
        end
        if (overrun_a) begin
            if (oa.size() == 0) check("a_overrun_unexpected", oa.size(), 1);
            else begin
                oc = oa.pop_front();
                check("a_overrun_cyc", cyc, oc);
            end
        end
    end

    always @(negedge clk) begin
        if (start_b) begin
            if (sb.size() == 0) check("b_start_unexpected", sb.size(), 1);
            else begin
                eb = sb.pop_front();
                check("b_start_cyc", cyc, eb.cyc);
                check("b_start_id", grant_id_b, eb.id);
            end
        end
        if (done_b) begin
            if (db.size() == 0) check("b_done_unexpected", db.size(), 1);
            else begin
                eb = db.pop_front();
                check("b_done_cyc", cyc, eb.cyc);
                check("b_done_id", done_id_b, eb.id);
            end
        end
        if (overrun_b) begin
            if (ob.size() == 0) check("b_overrun_unexpected", ob.size(), 1);
            else begin
                oc = ob.pop_front();
                check("b_overrun_cyc", cyc, oc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        reset_n = 1'b0;
        req_a = '0; req_b = '0; dly_a = '0; dly_b = '0;
        repeat (2) @(negedge clk);
        check("rst_pending_a", pending_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_start_a", start_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_grant_id_a", grant_id_a, 0);
        check("rst_done_id_a", done_id_a, 0);
        check("rst_overrun_a", overrun_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_pending_b", pending_b, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, D=5, GUARD=2
        c = cyc; req_a = 4'b0001; dly_a = 16'd5;
        sa.push_back('{c + 2, 0}); da.push_back('{c + 7, 0});
        @(negedge clk); req_a = '0;
        check("t1_pend_set", pending_a, 4'b0001);
        @(negedge clk);
        check("t1_pend_clr", pending_a, 0);
        for (int k = 0; k < 7; k++) begin
            check("t1_busy", busy_a, 1);
            @(negedge clk);
        end
        check("t1_idle", busy_a, 0);

        // Round-robin on GUARD=0 instance: first priority is ID 0 after reset
        c = cyc; req_b = 4'b1111; dly_b = 16'd3;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{c + 2 + 4 * k, k});
            db.push_back('{c + 5 + 4 * k, k});
        end
        @(negedge clk); req_b = '0;
        check("t2_pend_all", pending_b, 4'b1111);
        wait_to(c + 16);
        check("t2_busy_last", busy_b, 1);
        wait_to(c + 17);
        check("t2_busy_at_done", busy_b, 0);
        wait_to(c + 19);

        // Fairness: after ID 2, req 0101 scans 3,0 -> 0 then 2
        c = cyc; req_b = 4'b0100; dly_b = 16'd3;
        sb.push_back('{c + 2, 2}); db.push_back('{c + 5, 2});
        @(negedge clk); req_b = '0;
        wait_to(c + 3);
        req_b = 4'b0101;
        sb.push_back('{c + 6, 0});  db.push_back('{c + 9, 0});
        sb.push_back('{c + 10, 2}); db.push_back('{c + 13, 2});
        @(negedge clk); req_b = '0;
        check("t3_pend_0101", pending_b, 4'b0101);
        wait_to(c + 15);

        // Zero delay on GUARD=2 instance, then D=1 for comparison
        c = cyc; req_a = 4'b0010; dly_a = 16'd0;
        sa.push_back('{c + 2, 1}); da.push_back('{c + 3, 1});
        @(negedge clk); req_a = '0;
        wait_to(c + 4);
        check("t4_busy_guard_end", busy_a, 1);
        wait_to(c + 5);
        check("t4_idle", busy_a, 0);
        c = cyc; req_a = 4'b0100; dly_a = 16'd1;
        sa.push_back('{c + 2, 2}); da.push_back('{c + 3, 2});
        @(negedge clk); req_a = '0;
        wait_to(c + 6);

        // Overrun and merge; delay_cycles changed mid-delay only affects next grant
        c = cyc; req_a = 4'b0001; dly_a = 16'd10;
        sa.push_back('{c + 2, 0}); da.push_back('{c + 12, 0});
        oa.push_back(c + 6); oa.push_back(c + 7);
        sa.push_back('{c + 15, 1}); da.push_back('{c + 19, 1});
        @(negedge clk); req_a = '0;
        wait_to(c + 3); dly_a = 16'd4;
        wait_to(c + 4); req_a = 4'b0010;
        wait_to(c + 7); req_a = '0;
        @(negedge clk);
        check("t5_pend_merged", pending_a, 4'b0010);
        wait_to(c + 22);
        check("t5_idle", busy_a, 0);

        // Request on the same edge as its grant re-arms pending without overrun
        c = cyc; req_a = 4'b1000; dly_a = 16'd2;
        sa.push_back('{c + 2, 3}); da.push_back('{c + 4, 3});
        sa.push_back('{c + 7, 3}); da.push_back('{c + 9, 3});
        wait_to(c + 2); req_a = '0;
        check("t5b_pend_rearm", pending_a, 4'b1000);
        wait_to(c + 13);

        // Reset mid-delay aborts without done
        c = cyc; req_a = 4'b0001; dly_a = 16'd10;
        sa.push_back('{c + 2, 0});
        @(negedge clk); req_a = '0;
        wait_to(c + 3); req_a = 4'b0110;
        wait_to(c + 4); req_a = '0;
        check("t6_pend_before_rst", pending_a, 4'b0110);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_pending", pending_a, 0);
        check("t6_rst_start", start_a, 0);
        check("t6_rst_done", done_a, 0);
        check("t6_rst_grant_id", grant_id_a, 0);
        check("t6_rst_overrun", overrun_a, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c = cyc; req_a = 4'b0010; dly_a = 16'd3;
        sa.push_back('{c + 2, 1}); da.push_back('{c + 5, 1});
        @(negedge clk); req_a = '0;
        wait_to(c + 10);

        check("left_sa", sa.size(), 0);
        check("left_da", da.size(), 0);
        check("left_oa", oa.size(), 0);
        check("left_sb", sb.size(), 0);
        check("left_db", db.size(), 0);
        check("left_ob", ob.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
